// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with almost flags, fill count, sticky error
// flags, synchronous flush and optional first-word-fall-through read.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   w_en,
  input  logic [WIDTH-1:0]       d_in,
  input  logic                   r_en,
  output logic [WIDTH-1:0]       d_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [WIDTH-1:0] r_dout;
  logic             r_ovf;
  logic             r_udf;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [WIDTH-1:0] w_head;

  // Pointers carry one extra wrap bit, so their difference is the fill level
  assign count        = r_wptr - r_rptr;
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

  assign w_wr_acc = w_en && !full && !clr && rst;
  assign w_rd_acc = r_en && !empty;
  assign w_head   = r_mem[r_rptr[AW-1:0]];

  // Storage is deliberately left out of reset and flush
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr[AW-1:0]] <= d_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_dout <= '0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else if (clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_dout <= '0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      if (w_en && full)  r_ovf <= 1'b1;
      if (r_en && empty) r_udf <= 1'b1;
      // In FWFT mode r_dout tracks the presented head so it can be held once empty
      if (FWFT != 0) begin
        if (!empty) r_dout <= w_head;
      end else begin
        if (w_rd_acc) r_dout <= w_head;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign d_out = empty ? r_dout : w_head;
    end else begin : g_std
      assign d_out = r_dout;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: standard and FWFT instances share stimulus and
// are compared every cycle against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int W = 8;
  localparam int D = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic         w_en;
  logic         r_en;
  logic [W-1:0] d_in;

  logic [W-1:0] s_dout, f_dout;
  logic         s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic         f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0]   s_count, f_count;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [W-1:0] q[$];
  bit           m_ovf, m_udf;
  logic [W-1:0] m_dout, m_last;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .d_in(d_in), .r_en(r_en),
    .d_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_udf));

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .d_in(d_in), .r_en(r_en),
    .d_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_udf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 0;
    m_udf  = 0;
    m_dout = '0;
    m_last = '0;
  endtask

  // Applies one clock edge worth of FIFO rules to the model
  task automatic model_step(input bit w, input bit r, input logic [W-1:0] d, input bit c);
    bit mfull, mempty;
    if (!rst || c) begin
      model_reset();
    end else begin
      mfull  = (q.size() == D);
      mempty = (q.size() == 0);
      if (w && mfull)  m_ovf = 1;
      if (r && mempty) m_udf = 1;
      if (!mempty) m_last = q[0];
      if (r && !mempty) m_dout = q.pop_front();
      if (w && !mfull) q.push_back(d);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = q.size();
    chk({tag, ":count"},   s_count, sz);
    chk({tag, ":full"},    s_full,  sz == D);
    chk({tag, ":empty"},   s_empty, sz == 0);
    chk({tag, ":afull"},   s_af,    sz >= AF);
    chk({tag, ":aempty"},  s_ae,    sz <= AE);
    chk({tag, ":ovf"},     s_ovf,   m_ovf);
    chk({tag, ":udf"},     s_udf,   m_udf);
    chk({tag, ":dout"},    s_dout,  m_dout);
    chk({tag, ":f_count"}, f_count, sz);
    chk({tag, ":f_empty"}, f_empty, sz == 0);
    chk({tag, ":f_full"},  f_full,  sz == D);
    chk({tag, ":f_ovf"},   f_ovf,   m_ovf);
    chk({tag, ":f_udf"},   f_udf,   m_udf);
    chk({tag, ":f_dout"},  f_dout,  (sz != 0) ? q[0] : m_last);
  endtask

  task automatic cyc(input string tag, input bit w, input bit r, input logic [W-1:0] d, input bit c);
    w_en = w; r_en = r; d_in = d; clr = c;
    model_step(w, r, d, c);
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; w_en = 1'b0; r_en = 1'b0; d_in = '0;
    model_reset();
    cyc("reset", 0, 0, 8'h00, 0);
    cyc("reset", 0, 0, 8'h00, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // fill 0x00..0x0F then drain
    for (int i = 0; i < 16; i++) cyc("fill", 1, 0, 8'(i), 0);
    cyc("ovf_write", 1, 0, 8'hAA, 0);
    for (int i = 0; i < 16; i++) cyc("drain", 0, 1, 8'h00, 0);
    cyc("udf_read", 0, 1, 8'h00, 0);
    cyc("idle", 0, 0, 8'h00, 0);
    cyc("clr", 0, 0, 8'h00, 1);

    // simultaneous read/write at count 5 across pointer wraps
    for (int i = 0; i < 5; i++) cyc("pre5", 1, 0, 8'(8'h40 + i), 0);
    for (int i = 0; i < 40; i++) cyc("rw5", 1, 1, 8'(8'h45 + i), 0);

    // both requests while full: read wins, write is dropped
    for (int i = 0; i < 11; i++) cyc("fill16", 1, 0, 8'(8'hC0 + i), 0);
    cyc("rw_full", 1, 1, 8'hEE, 0);
    cyc("clr2", 1, 1, 8'h33, 1);

    // FWFT presentation and hold after pop
    cyc("fwft_wr", 1, 0, 8'h5A, 0);
    cyc("fwft_idle", 0, 0, 8'h00, 0);
    cyc("fwft_pop", 0, 1, 8'h00, 0);
    cyc("fwft_hold", 0, 0, 8'h00, 0);

    // asynchronous reset mid-cycle at count 7
    for (int i = 0; i < 7; i++) cyc("pre7", 1, 0, 8'(8'h70 + i), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    w_en = 1'b0; r_en = 1'b0;
    @(posedge clk); #1;
    check_all("rst_held");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    cyc("post_rst_wr", 1, 0, 8'h11, 0);
    cyc("post_rst_rd", 0, 1, 8'h00, 0);

    // random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      bit w, r, c;
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 2);
      cyc("rand", w, r, 8'($urandom), c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, the next generation of the team's 16×8 FIFO. It generalises width and depth and adds almost-full/almost-empty thresholds, a fill count, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It sits between same-clock producer and consumer stages: packet buffers, rate smoothing, and holding data ahead of a clock-domain crossing.

## Interface
Parameters:
- WIDTH, 8: data word width in bits, ≥1.
- DEPTH, 16: number of storage entries; power of two, ≥2.
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL; range 0..DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush, active-high.
- w_en  in  1  write request.
- d_in  in  WIDTH  write data.
- r_en  in  1  read (pop) request.
- d_out  out  WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current number of stored words.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

## Operation
- Pointers: w_ptr and r_ptr are $clog2(DEPTH)+1 bits wide. The low bits address memory. The counters wrap modulo 2·DEPTH, with no special case at the wrap.
- Flags: full, empty, almost_full, almost_empty and count are derived from registered state only. There is no combinational path from w_en or r_en to any flag.
- Write accept = w_en && !full. On accept, mem[w_ptr] <= d_in and w_ptr increments.
- Read accept = r_en && !empty. On accept, r_ptr increments.
- A write is never accepted while full, even if a read is accepted in the same cycle.
- Count update per cycle:
  - +1 on write-only accept.
  - −1 on read-only accept.
  - Unchanged when both are accepted, or when neither is.
- Standard mode (FWFT=0):
  - On read accept, d_out <= mem[r_ptr].
  - Otherwise d_out holds its value.
- FWFT mode (FWFT=1):
  - d_out continuously presents mem[r_ptr] whenever empty is 0.
  - r_en acknowledges and pops the presented word.
  - While empty, d_out holds the last presented value.
- Write attempted while full: data is dropped, overflow sets to 1, and there is no other state change.
- Read attempted while empty: underflow sets to 1. d_out and r_ptr are unchanged.
- Overflow and underflow clear only on rst or clr.
- clr (synchronous, overrides w_en and r_en in the same cycle):
  - Pointers, count, overflow, underflow and d_out go to 0.
  - Memory contents are not cleared.
- Reset (rst low, asynchronous): same state as clr.
  - Output values during and after reset: d_out=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0 (given AF_LEVEL ≥ 1), overflow=0, underflow=0.
  - Memory is not reset.
- Reset deasserted mid-operation: all in-flight data is discarded. The first accepted write after release lands at address 0.

## Timing
- Write at edge N:
  - count, empty and the almost flags update after edge N.
  - FWFT: the word is on d_out in cycle N+1 (after edge N).
  - Standard: the earliest read accept is at edge N+1, and d_out is valid after edge N+1.
- Read latency:
  - Standard: 1 cycle from accept edge to d_out.
  - FWFT: 0 cycles, because data is presented before the accept.
- Full-to-not-full: the first read accept at edge N clears full after edge N, and a write is accepted at edge N+1.
- Throughput: one write and one read per cycle when neither full nor empty.

## Test plan
- Fill/drain, DEPTH=16, WIDTH=8, FWFT=0:
  - Write 0x00..0x0F on consecutive cycles, then read 16 times.
  - Required: full=1 after the 16th write. d_out is 0x00..0x0F in order, each 1 cycle after its accept. empty=1 after the last read, with count tracking 0→16→0.
- Overflow/underflow:
  - At full, write 0xAA. Required: overflow=1, count stays 16, 0xAA never appears on d_out.
  - Drain, then read once more. Required: underflow=1, d_out unchanged.
  - Assert clr. Required: both flags 0, count 0, empty=1.
- Thresholds, AF_LEVEL=14, AE_LEVEL=2:
  - almost_empty is 1 at count 0..2 and 0 at count 3.
  - almost_full is 0 at count 13 and 1 at count 14..16.
- Simultaneous read and write:
  - At count 5, hold w_en and r_en high for 40 cycles with incrementing data. Required: count stays 5, output order is preserved across both pointer wraps, no flag toggles.
  - At count 16 with both w_en and r_en high: the read is accepted, the write is rejected, overflow=1, count becomes 15.
- FWFT=1:
  - Write 0x5A. Required: d_out=0x5A and empty=0 in the next cycle with no r_en.
  - Pulse r_en. Required: empty=1 next cycle, d_out holds 0x5A.
- Asynchronous reset:
  - At count 7, drive rst low mid-cycle. Required: all outputs take their reset values immediately, without a clock edge.
  - Release rst, then write 0x11. Required: 0x11 is the first word read back.
